// File: rtl/run_sequencer.sv
// run_sequencer: sequences one CPU test run (reset hold, run with limit, drain, finish).
module run_sequencer #(
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic          cpu_done,
  input  logic [CW-1:0] max_count,
  output logic          cpu_reset,
  output logic          cpu_en,
  output logic          busy,
  output logic          finish,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);
  localparam int SMAX = RESET_CYCLES > DRAIN_CYCLES ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int SW = $clog2(SMAX + 1);
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic trig_q, accept, hit;
  logic [SW-1:0] sub, sub_n;
  logic [CW-1:0] limit, limit_n, cnt_n;
  logic rst_n_o, en_n, busy_n, fin_n, to_n;
  assign accept = trigger & ~trig_q & (state == IDLE || state == DONE);
  assign hit = (limit != '0) && (cycle_count + CW'(1) == limit);
  always_comb begin
    state_n = state;
    sub_n = sub;
    limit_n = limit;
    cnt_n = cycle_count;
    rst_n_o = cpu_reset;
    en_n = cpu_en;
    busy_n = busy;
    fin_n = finish;
    to_n = timeout;
    if (accept) begin
      state_n = HOLD;
      sub_n = '0;
      limit_n = max_count;
      cnt_n = '0;
      rst_n_o = 1'b1;
      en_n = 1'b0;
      busy_n = 1'b1;
      fin_n = 1'b0;
      to_n = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          sub_n = sub + SW'(1);
          if (sub == SW'(RESET_CYCLES - 1)) begin
            state_n = RUN;
            rst_n_o = 1'b0;
            en_n = 1'b1;
          end
        end
        RUN: begin
          cnt_n = cycle_count + CW'(1);
          if (cpu_done || hit) begin
            state_n = DRAIN;
            sub_n = '0;
            en_n = 1'b0;
            to_n = ~cpu_done;
          end
        end
        DRAIN: begin
          sub_n = sub + SW'(1);
          if (sub == SW'(DRAIN_CYCLES - 1)) begin
            state_n = DONE;
            fin_n = 1'b1;
            busy_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      trig_q <= 1'b0;
      sub <= '0;
      limit <= '0;
      cycle_count <= '0;
      cpu_reset <= 1'b1;
      cpu_en <= 1'b0;
      busy <= 1'b0;
      finish <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      trig_q <= trigger;
      sub <= sub_n;
      limit <= limit_n;
      cycle_count <= cnt_n;
      cpu_reset <= rst_n_o;
      cpu_en <= en_n;
      busy <= busy_n;
      finish <= fin_n;
      timeout <= to_n;
    end
  end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed self-checking bench for run_sequencer.
module tb_run_sequencer;
  logic clk = 1'b0, reset, trigger, cpu_done;
  logic [31:0] max_count, cycle_count;
  logic cpu_reset, cpu_en, busy, finish, timeout;
  int total = 0, fails = 0;
  run_sequencer dut (
    .clk(clk), .reset(reset), .trigger(trigger), .cpu_done(cpu_done),
    .max_count(max_count), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy),
    .finish(finish), .timeout(timeout), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  // Runs one trigger-to-finish sequence; done_at=0 means cpu_done never rises.
  task automatic do_run(string tag, int mc, int done_at, int exp_cnt, bit exp_to, int extra_at);
    int n;
    max_count = mc;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk({tag, " busy@accept"}, busy, 1);
    chk({tag, " finish@accept"}, finish, 0);
    n = 0;
    while (cpu_reset && n < 100) begin n++; @(negedge clk); end
    chk({tag, " reset_cycles"}, n, 4);
    n = 0;
    while (cpu_en && n < 2000) begin
      n++;
      if (done_at > 0 && cycle_count == done_at - 1) cpu_done = 1'b1;
      if (extra_at > 0) trigger = (cycle_count == extra_at);
      @(negedge clk);
    end
    cpu_done = 1'b0;
    trigger = 1'b0;
    chk({tag, " en_cycles"}, n, exp_cnt);
    n = 0;
    while (!finish && n < 100) begin
      chk({tag, " busy@drain"}, busy, 1);
      n++;
      @(negedge clk);
    end
    chk({tag, " drain_cycles"}, n, 2);
    chk({tag, " cycle_count"}, cycle_count, exp_cnt);
    chk({tag, " timeout"}, timeout, exp_to);
    chk({tag, " busy@finish"}, busy, 0);
    chk({tag, " cpu_en@finish"}, cpu_en, 0);
    chk({tag, " cpu_reset@finish"}, cpu_reset, 0);
  endtask
  // Holds trigger high from DONE for hold cycles; exactly one run must start.
  task automatic level_trig(string tag, int hold);
    int rises, fin_seen;
    logic pb;
    rises = 0;
    fin_seen = 0;
    max_count = 3;
    pb = busy;
    trigger = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, " finish_cleared"}, finish, 0);
      if (i == hold - 1) trigger = 1'b0;
      if (busy && !pb) rises++;
      if (finish) fin_seen++;
      pb = busy;
    end
    chk({tag, " accepts"}, rises, 1);
    chk({tag, " finish_end"}, finish, 1);
    chk({tag, " finish_cycles"}, fin_seen, 21);
    chk({tag, " cycle_count"}, cycle_count, 3);
    chk({tag, " timeout"}, timeout, 1);
  endtask
  initial begin
    int n;
    reset = 1'b0;
    trigger = 1'b0;
    cpu_done = 1'b0;
    max_count = 0;
    repeat (3) @(negedge clk);
    chk("rst cpu_reset", cpu_reset, 1);
    chk("rst cpu_en", cpu_en, 0);
    chk("rst busy", busy, 0);
    chk("rst finish", finish, 0);
    chk("rst timeout", timeout, 0);
    chk("rst count", cycle_count, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle cpu_reset", cpu_reset, 1);
    do_run("basic", 100, 20, 20, 0, 0);
    do_run("tmo", 10, 0, 10, 1, 0);
    do_run("simul", 5, 5, 5, 0, 0);
    do_run("unlim", 0, 300, 300, 0, 50);
    do_run("first", 0, 1, 1, 0, 0);
    max_count = 0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    n = 0;
    while (!(cpu_en && cycle_count == 7) && n < 100) begin n++; @(negedge clk); end
    chk("mid count7", cycle_count, 7);
    reset = 1'b0;
    #1;
    chk("mid cpu_reset", cpu_reset, 1);
    chk("mid cpu_en", cpu_en, 0);
    chk("mid busy", busy, 0);
    chk("mid count", cycle_count, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (finish) n++;
      if (i == 3) reset = 1'b1;
    end
    chk("mid no_finish", n, 0);
    chk("mid idle busy", busy, 0);
    do_run("restart", 3, 0, 3, 1, 0);
    level_trig("lvl5", 5);
    level_trig("lvl15", 15);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Synchronous run controller that sequences one CPU test run.
- On a trigger pulse it holds the CPU in reset for a fixed number of cycles, then enables execution. It counts executed cycles and stops on CPU `done` or on a cycle limit.
- After a drain interval for memory writes to settle, it raises `finish` with status.
- Sits between the bench/host trigger and the `cpu`/`dmem` pair.

Parameters:
- RESET_CYCLES, 4, cycles `cpu_reset` is held high after a trigger is accepted (≥1)
- DRAIN_CYCLES, 2, cycles waited after the stop condition before `finish` (≥1)
- CW, 32, width of `max_count` and `cycle_count`

Ports:
- clk  input  1  single system clock, all state on posedge
- reset  input  1  reset; asynchronous and active-low (0 = reset)
- trigger  input  1  start request; a rising edge starts a run
- cpu_done  input  1  CPU completion flag, level, sampled on posedge
- max_count  input  CW  cycle limit, latched at trigger acceptance; 0 = unlimited
- cpu_reset  output  1  active-high reset to the CPU
- cpu_en  output  1  CPU clock-enable/run qualifier
- busy  output  1  high from trigger acceptance until `finish` rises
- finish  output  1  run complete; level, held until the next accepted trigger
- timeout  output  1  valid with `finish`: 1 = stopped by limit, 0 = stopped by `cpu_done`
- cycle_count  output  CW  number of RUN-state cycles executed in the current/last run

Behaviour:
- All outputs are registered.
- Reset values (`reset`=0, asynchronous): state IDLE, `cpu_reset`=1, `cpu_en`=0, `busy`=0, `finish`=0, `timeout`=0, `cycle_count`=0, trigger history register=0, latched limit=0, sub-counter=0.
- Trigger detection: `trig_q` registers `trigger`. A rising edge is `trigger`=1 and `trig_q`=0 at a posedge. A 1-cycle pulse suffices. Level-high `trigger` does not retrigger.
- Trigger acceptance: accepted only in IDLE or DONE. Ignored in RESET_HOLD, RUN and DRAIN, with no effect on any output.
- On acceptance:
  - latch `max_count`; clear `cycle_count`, `finish` and `timeout`
  - `busy`=1, `cpu_reset`=1, `cpu_en`=0
  - sub-counter=0; go to RESET_HOLD
- States:
  - IDLE: `cpu_reset`=1, `cpu_en`=0. Waits for a trigger.
  - RESET_HOLD: sub-counter increments each cycle. When it reaches RESET_CYCLES-1, go to RUN with `cpu_reset`=0 and `cpu_en`=1. `cpu_reset` is therefore high for exactly RESET_CYCLES cycles after acceptance.
  - RUN: `cycle_count` increments by 1 each cycle; wraps modulo 2^CW only when the limit is 0. Stop checks each posedge:
    - a) `cpu_done`=1 → stop, `timeout`=0
    - b) limit≠0 and `cycle_count`+1 == limit → stop, `timeout`=1
    - If both hold in the same cycle, `cpu_done` wins: `timeout`=0.
    - On stop, the current cycle still counts. `cpu_en`=0 and `cpu_reset` stays 0 from the next cycle. Sub-counter=0; go to DRAIN.
    - `cpu_done` high in the first RUN cycle yields `cycle_count`=1.
  - DRAIN: `cpu_en`=0 and `cycle_count` frozen. After DRAIN_CYCLES cycles, go to DONE with `finish`=1 and `busy`=0.
  - DONE: outputs held, `cpu_reset` stays 0 so CPU state remains observable. A new trigger restarts via acceptance.
- `cpu_done` is ignored outside RUN. If it is still high from a prior run, it is re-evaluated only once RUN is re-entered.
- Reset asserted mid-run: immediate return to reset values; a run in progress is abandoned with no `finish`.
- Latency: trigger edge at posedge k gives `cpu_en`=1 from posedge k+RESET_CYCLES. Stop detected at posedge s gives `finish`=1 from posedge s+DRAIN_CYCLES.

Test Plan:
- **Basic run.** Reset low 3 cycles then high, `max_count`=100, 1-cycle trigger, `cpu_done` raised after 20 RUN cycles. Expect `cpu_reset` high 4 cycles, `cpu_en` high 20 cycles, `finish`=1 2 cycles later, `cycle_count`=20, `timeout`=0, `busy` low.
- **Timeout.** `max_count`=10, `cpu_done` held 0. Expect `cpu_en` high exactly 10 cycles, `cycle_count`=10, `timeout`=1, `finish`=1.
- **Simultaneous stop.** `max_count`=5, `cpu_done` rising in the 5th RUN cycle. Expect `cycle_count`=5, `timeout`=0.
- **Unlimited limit and ignored trigger.** `max_count`=0 with done at cycle 300, plus a second trigger pulse during RUN. Expect the extra trigger ignored, `cycle_count`=300, `timeout`=0.
- **Reset mid-run and restart.** Assert reset during RUN at cycle 7. Expect all outputs at reset values immediately, `finish` never rises. Then trigger with `max_count`=3: run completes with `cycle_count`=3, `timeout`=1.
- **Re-trigger from DONE.** After `finish`, hold `trigger` high for 5 cycles. Expect exactly one new run: `finish` cleared at acceptance, no second acceptance while the level stays high.
